// File: rtl/cpu_ctrl_trace_encoder.sv
// Taps decoder control bundles at retire, re-encodes them into an instruction class and
// queues {gap, seq, cls, pc} records in a FIFO drained through a valid/ready port.
module cpu_ctrl_trace_encoder #(
  parameter int PC_W  = 32,
  parameter int SEQ_W = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      trace_en,
  input  logic                      valid_in,
  input  logic [PC_W-1:0]           pc_in,
  input  logic [14:0]               ctrl_vec,
  output logic                      t_valid,
  input  logic                      t_ready,
  output logic [SEQ_W+PC_W+4:0]     t_data,
  output logic [15:0]               drop_cnt,
  output logic                      done
);

  localparam int REC_W = 1 + SEQ_W + 4 + PC_W;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Bit order: {beq,bne,bltz,halt,aluop[1:0],memread,memwrite,memtoreg,regdst,regwrite,alusrc_a,alusrc_b,extsel,jump}
  localparam logic [14:0] V_RTYPE  = 15'h0432;
  localparam logic [14:0] V_LOGIMM = 15'h0414;
  localparam logic [14:0] V_ADDIU  = 15'h0016;
  localparam logic [14:0] V_SLTI   = 15'h0416;
  localparam logic [14:0] V_SLL    = 15'h043A;
  localparam logic [14:0] V_LW     = 15'h0156;
  localparam logic [14:0] V_SW     = 15'h0086;
  localparam logic [14:0] V_BEQ    = 15'h4222;
  localparam logic [14:0] V_BNE    = 15'h2222;
  localparam logic [14:0] V_BLTZ   = 15'h1422;
  localparam logic [14:0] V_J      = 15'h0433;
  localparam logic [14:0] V_HALT   = 15'h0C32;
  localparam logic [3:0]  CLS_HALT = 4'hB;

  typedef enum logic [1:0] {RUN, DRAIN, FINISHED} state_t;

  state_t            state;
  logic [REC_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_nxt;
  logic [SEQ_W-1:0]  seq;
  logic              gap;
  logic [3:0]        cls;
  logic              full, retire, pop, push, drop;

  always_comb begin
    cls = 4'hF;
    case (ctrl_vec)
      V_RTYPE:  cls = 4'h0;
      V_LOGIMM: cls = 4'h1;
      V_ADDIU:  cls = 4'h2;
      V_SLTI:   cls = 4'h3;
      V_SLL:    cls = 4'h4;
      V_LW:     cls = 4'h5;
      V_SW:     cls = 4'h6;
      V_BEQ:    cls = 4'h7;
      V_BNE:    cls = 4'h8;
      V_BLTZ:   cls = 4'h9;
      V_J:      cls = 4'hA;
      V_HALT:   cls = 4'hB;
      default:  cls = 4'hF;
    endcase
  end

  assign full    = (count == (AW+1)'(DEPTH));
  assign t_valid = (count != '0);
  assign pop     = t_valid & t_ready;
  assign retire  = valid_in & trace_en & (state == RUN);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push    = retire & (~full | pop);
  assign drop    = retire & full & ~pop;
  assign t_data  = t_valid ? mem[rd_ptr] : '0;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {gap, seq, cls, pc_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      gap      <= 1'b0;
      drop_cnt <= '0;
      state    <= RUN;
      done     <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (retire) seq <= seq + SEQ_W'(1);
      if (push) gap <= 1'b0;
      else if (drop) begin
        gap <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      case (state)
        RUN: if (retire && cls == CLS_HALT) state <= DRAIN;
        DRAIN: if (count_nxt == '0) begin
          state <= FINISHED;
          done  <= 1'b1;
        end
        default: done <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_trace_encoder.sv
// Randomized bench for cpu_ctrl_trace_encoder against a queue-based reference model.
module tb_cpu_ctrl_trace_encoder;
  localparam int PC_W = 32, SEQ_W = 8, DEPTH = 8;
  localparam int REC_W = 1 + SEQ_W + 4 + PC_W;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              trace_en = 1'b0, valid_in = 1'b0, t_ready = 1'b0;
  logic [PC_W-1:0]   pc_in = '0;
  logic [14:0]       ctrl_vec = '0;
  logic              t_valid, done;
  logic [REC_W-1:0]  t_data;
  logic [15:0]       drop_cnt;

  cpu_ctrl_trace_encoder #(.PC_W(PC_W), .SEQ_W(SEQ_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .valid_in(valid_in), .pc_in(pc_in),
    .ctrl_vec(ctrl_vec), .t_valid(t_valid), .t_ready(t_ready), .t_data(t_data),
    .drop_cnt(drop_cnt), .done(done));

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic beq, bne, bltz, halt;
    logic [1:0] aluop;
    logic memread, memwrite, memtoreg, regdst, regwrite, alusrc_a, alusrc_b, extsel, jump;
  } ctrl_t;

  // Class vectors built from named fields: base plus per-class deltas.
  function automatic logic [14:0] vec_of(input int c);
    ctrl_t v = '0;
    v.aluop = 2'b10; v.regdst = 1'b1; v.regwrite = 1'b1; v.extsel = 1'b1;
    case (c)
      1:  begin v.extsel = 0; v.regdst = 0; v.alusrc_b = 1; end
      2:  begin v.aluop = 2'b00; v.regdst = 0; v.alusrc_b = 1; end
      3:  begin v.regdst = 0; v.alusrc_b = 1; end
      4:  v.alusrc_a = 1;
      5:  begin v.memread = 1; v.memtoreg = 1; v.aluop = 2'b00; v.regdst = 0; v.alusrc_b = 1; end
      6:  begin v.memwrite = 1; v.aluop = 2'b00; v.regdst = 0; v.alusrc_b = 1; v.regwrite = 0; end
      7:  begin v.beq = 1; v.aluop = 2'b01; v.regwrite = 0; end
      8:  begin v.bne = 1; v.aluop = 2'b01; v.regwrite = 0; end
      9:  begin v.bltz = 1; v.regwrite = 0; end
      10: v.jump = 1;
      11: v.halt = 1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] class_of(input logic [14:0] vec);
    for (int c = 0; c < 12; c++) if (vec_of(c) == vec) return 4'(c);
    return 4'hF;
  endfunction

  function automatic logic [14:0] rnd_vec();
    if ($urandom_range(0, 15) == 0) return 15'($urandom);
    return vec_of($urandom_range(0, 10));
  endfunction

  // Reference model state
  logic [REC_W-1:0] q[$];
  int  m_seq, m_drop;
  bit  m_gap, m_drain, m_done;

  task automatic model_clear();
    q.delete();
    m_seq = 0; m_drop = 0; m_gap = 0; m_drain = 0; m_done = 0;
  endtask

  task automatic check_outputs();
    chk("t_valid", 64'(t_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk("t_data", 64'(t_data), 64'(q[0]));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("done", 64'(done), 64'(m_done));
  endtask

  // Called at a negedge: drive inputs, advance the model, clock, then check.
  task automatic cycle(input bit v, input logic [14:0] vec, input bit rdy, input bit en);
    bit pop, ev, was_drain, full;
    valid_in = v; ctrl_vec = vec; t_ready = rdy; trace_en = en; pc_in = $urandom;
    pop = (q.size() != 0) && rdy;
    ev = v && en && !m_drain;
    was_drain = m_drain;
    full = (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    if (ev) begin
      if (!full || pop) begin
        q.push_back({m_gap, 8'(m_seq), class_of(vec), pc_in});
        m_gap = 0;
      end else begin
        if (m_drop < 16'hFFFF) m_drop++;
        m_gap = 1;
      end
      if (class_of(vec) == 4'hB) m_drain = 1;
      m_seq = (m_seq + 1) % 256;
    end
    if (was_drain && q.size() == 0) m_done = 1;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid_in = 0; t_ready = 0; trace_en = 0; ctrl_vec = '0;
    #3;
    model_clear();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Class sweep: 0..A, illegal all-ones, then HALT and drain to done.
    for (int c = 0; c <= 10; c++) cycle(1, vec_of(c), 1, 1);
    cycle(1, 15'h7FFF, 1, 1);
    cycle(1, vec_of(11), 1, 1);
    for (int i = 0; i < 6; i++) cycle(0, '0, 1, 1);

    // Overflow, then a retire while full with a simultaneous pop.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, vec_of($urandom_range(0, 10)), 0, 1);
    chk("drop_after_overflow", 64'(drop_cnt), 64'd2);
    cycle(1, vec_of($urandom_range(0, 10)), 1, 1);
    chk("no_drop_on_full_pop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 12; i++) cycle(0, '0, 1, 1);

    // Random traffic with random backpressure and trace_en gaps.
    do_reset();
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, rnd_vec(), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) != 0);

    // Every-cycle toggling ready against a busy producer.
    for (int i = 0; i < 100; i++) cycle($urandom_range(0, 1) == 1, rnd_vec(), 1'(i % 2), 1);

    // Halt drain: SW after HALT is ignored, done rises and holds.
    do_reset();
    cycle(1, vec_of(5), 0, 1);
    cycle(1, vec_of(11), 0, 1);
    cycle(1, vec_of(6), 0, 1);
    for (int i = 0; i < 20; i++) cycle(1, rnd_vec(), 1'($urandom_range(0, 1)), 1);
    chk("done_held", 64'(done), 64'd1);

    // Asynchronous reset in the middle of a stream.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, vec_of($urandom_range(0, 10)), 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, vec_of($urandom_range(0, 10)), 0, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_t_valid", 64'(t_valid), 64'd0);
    chk("arst_t_data", 64'(t_data), 64'd0);
    chk("arst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++)
      cycle($urandom_range(0, 1) == 1, rnd_vec(), 1'($urandom_range(0, 1)), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
